raggedstone_spinn_aer_if_key_router: RTL and testbench
======================================================

// Module: raggedstone_spinn_aer_if_key_router
// PURPOSE
//  Table-driven SpiNNaker packet router with N outputs. It replaces the fixed 2-way mc/ctrl split.
//  Each multicast key is matched against runtime-written key/mask entries. The matching entry's
//  route bitmap replicates the packet to one or more outputs. Blocked packets are dropped after a
//  wait timeout and counted. Sits between the SpiNNaker link receiver and the out_mapper/ctrl blocks.
// PARAMETERS
//  PKT_BITS     72  packet width; header [7:0], key [39:8]
//  NUM_OUTS     4   output ports, 2..8
//  NUM_ENTRIES  4   routing-table entries, power of 2, 2..16
//  WAIT_CYCLES  255 cycles a held packet may wait before drop; 0 = never drop (wait forever)
// PORTS
//  clk          in   1                     clock
//  rst          in   1                     synchronous reset, active-high
//  spkt_data    in   PKT_BITS              incoming packet
//  spkt_vld     in   1                     incoming valid
//  spkt_rdy     out  1                     incoming ready
//  opkt_data    out  PKT_BITS              held packet, common to all outputs
//  opkt_vld     out  NUM_OUTS              per-output valid
//  opkt_rdy     in   NUM_OUTS              per-output ready
//  cfg_wr       in   1                     table write strobe
//  cfg_addr     in   clog2(NUM_ENTRIES)+2  [1:0] field (0 key, 1 mask, 2 route, 3 ignored); upper bits = entry
//  cfg_wdata    in   32                    write data; route uses [NUM_OUTS-1:0]
//  drop_cnt     out  16                    dropped-packet counter, saturating
//  drop_clr     in   1                     clear drop_cnt
// BEHAVIOUR
//  - Reset, synchronous: buffer empty, opkt_vld=0, opkt_data=0, spkt_rdy=1, drop_cnt=0, wait counter=0.
//    All keys=0 and masks=0. Route=0 except entry0 route=1, so all mc packets go to output 0.
//  - Accept when spkt_vld & spkt_rdy. The lookup is combinational on spkt_data and uses the
//    table value from before any same-cycle cfg_wr.
//  - Entry i hits when (key & mask[i]) == (key_i & mask[i]). The lowest-index hit wins.
//  - Multicast packet = spkt_data[7:6]==2'b00. A non-mc packet, or a miss, gets route=0.
//  - Route=0: the packet is consumed and dropped in the accept cycle, drop_cnt+1, buffer untouched.
//  - Route!=0: packet and pending<=route are registered. opkt_vld=pending from the next cycle,
//    so latency is 1 cycle.
//  - Each cycle: pending <= pending & ~opkt_rdy. Output k is done once it has seen vld&rdy.
//    opkt_vld[k] then falls and is never re-asserted for that packet.
//  - States:
//    EMPTY: pending==0.
//    HOLD: pending!=0.
//    HOLD->EMPTY when all pending are accepted or on timeout.
//  - spkt_rdy = EMPTY | ((pending & ~opkt_rdy)==0). A new packet may load in the cycle the last
//    pending output accepts, giving back-to-back throughput of 1 packet/cycle.
//  - Wait counter: cleared on every load. It increments each HOLD cycle in which no pending output
//    is accepted and the state stays HOLD; any acceptance clears it. When it reaches WAIT_CYCLES
//    (WAIT_CYCLES!=0), pending<=0 and drop_cnt+1, even if some outputs were already served.
//    The state returns to EMPTY. spkt_rdy stays 0 in the timeout cycle.
//  - drop_cnt saturates at 16'hFFFF. drop_clr has priority over an increment in the same cycle.
//    Two drop events in one cycle (route-0 accept plus timeout) are impossible, because a timeout
//    cycle has spkt_rdy=0.
//  - cfg_wr takes effect the next cycle. A held packet keeps the route latched at accept.
//  - Reset mid-HOLD discards the packet without counting it.
// CONFIGURATION
//  - `ROUTER_DEFAULT_ROUTE_EN defined: adds cfg field 3 = default route register (reset 0).
//    A multicast packet that misses every entry uses the default route. Non-mc packets are
//    still dropped.
//  - `ROUTER_DEFAULT_ROUTE_EN undefined: field-3 writes are ignored and every miss is dropped,
//    as above.
// TESTING
//  1. After reset, send a mc packet with key 32'h1234_5678 and all opkt_rdy=1. Expect
//     opkt_vld=4'b0001 one cycle after accept, data matching, drop_cnt=0.
//  2. Program entry1 key=32'hFF00_0000, mask=32'hFF00_0000, route=4'b0110 and entry0 mask=
//     32'hFFFF_FFFF, key=0. Send key 32'hFF12_3456 with opkt_rdy[1]=1 and opkt_rdy[2] held low
//     3 cycles. Expect vld[1] for 1 cycle, vld[2] for 4 cycles, spkt_rdy=0 until the cycle
//     output 2 accepts.
//  3. Keep WAIT_CYCLES=255 and hold all opkt_rdy=0 after a packet loads. Expect the buffer to
//     drop after 255 stalled cycles, drop_cnt=1, then spkt_rdy=1.
//  4. Send a header with [7:6]=2'b10 (nn packet). Expect no opkt_vld, spkt_rdy=1 throughout,
//     drop_cnt+1. Repeat with drop_clr asserted in the same cycle; expect drop_cnt=0.
//  5. Stream 8 back-to-back packets with all rdy=1. Expect 8 consecutive opkt_vld cycles and no
//     bubble. Assert rst in cycle 4; expect opkt_vld=0 the next cycle and drop_cnt unchanged at 0.
//  6. With `ROUTER_DEFAULT_ROUTE_EN, write default=4'b1000 and send a missing mc key. Expect
//     opkt_vld=4'b1000. Without the macro, expect a drop and drop_cnt=1.

Source files
------------

// File: rtl/raggedstone_spinn_aer_if_key_router.sv
// Table-driven SpiNNaker packet router: key/mask lookup, multicast replication, timeout drop.
// Optional `ROUTER_DEFAULT_ROUTE_EN adds a default route for multicast misses (cfg field 3).
module raggedstone_spinn_aer_if_key_router #(
    parameter int PKT_BITS    = 72,
    parameter int NUM_OUTS    = 4,
    parameter int NUM_ENTRIES = 4,
    parameter int WAIT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PKT_BITS-1:0]            spkt_data,
    input  logic                           spkt_vld,
    output logic                           spkt_rdy,
    output logic [PKT_BITS-1:0]            opkt_data,
    output logic [NUM_OUTS-1:0]            opkt_vld,
    input  logic [NUM_OUTS-1:0]            opkt_rdy,
    input  logic                           cfg_wr,
    input  logic [$clog2(NUM_ENTRIES)+1:0] cfg_addr,
    input  logic [31:0]                    cfg_wdata,
    output logic [15:0]                    drop_cnt,
    input  logic                           drop_clr
);
    // state | meaning
    // EMPTY | no packet held, pending == 0
    // HOLD  | packet held, at least one output still pending
    typedef enum logic {EMPTY, HOLD} state_t;

    localparam int IDX_W  = $clog2(NUM_ENTRIES);
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t              state;
    logic [NUM_OUTS-1:0] pending;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         key_tab   [NUM_ENTRIES];
    logic [31:0]         mask_tab  [NUM_ENTRIES];
    logic [NUM_OUTS-1:0] route_tab [NUM_ENTRIES];
`ifdef ROUTER_DEFAULT_ROUTE_EN
    logic [NUM_OUTS-1:0] default_route;
`endif

    logic [31:0]         pkt_key;
    logic                is_mc;
    logic                hit;
    logic [NUM_OUTS-1:0] lookup_route;
    logic [NUM_OUTS-1:0] remaining;
    logic                any_acc;
    logic                accept;
    logic                timeout;
    logic                drop_evt;
    logic [IDX_W-1:0]    cfg_idx;

    assign pkt_key = spkt_data[39:8];
    assign is_mc   = (spkt_data[7:6] == 2'b00);
    assign cfg_idx = cfg_addr[IDX_W+1:2];

    // Lowest-index hit wins; table contents are the pre-write values this cycle.
    always_comb begin
        hit          = 1'b0;
        lookup_route = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!hit && ((pkt_key & mask_tab[i]) == (key_tab[i] & mask_tab[i]))) begin
                hit          = 1'b1;
                lookup_route = route_tab[i];
            end
        end
`ifdef ROUTER_DEFAULT_ROUTE_EN
        if (!hit)
            lookup_route = default_route;
`endif
        if (!is_mc)
            lookup_route = '0;
    end

    assign opkt_vld  = pending;
    assign remaining = pending & ~opkt_rdy;
    assign any_acc   = |(pending & opkt_rdy);
    assign spkt_rdy  = (state == EMPTY) || (remaining == '0);
    assign accept    = spkt_vld && spkt_rdy;
    assign timeout   = (WAIT_CYCLES != 0) && (state == HOLD) && (remaining != '0) &&
                       !any_acc && (wait_cnt == WAIT_LAST);
    assign drop_evt  = (accept && (lookup_route == '0)) || timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pending   <= '0;
            wait_cnt  <= '0;
            opkt_data <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                key_tab[i]   <= '0;
                mask_tab[i]  <= '0;
                route_tab[i] <= (i == 0) ? NUM_OUTS'(1) : '0;
            end
`ifdef ROUTER_DEFAULT_ROUTE_EN
            default_route <= '0;
`endif
        end else begin
            if (cfg_wr) begin
                case (cfg_addr[1:0])
                    2'd0:    key_tab[cfg_idx]   <= cfg_wdata;
                    2'd1:    mask_tab[cfg_idx]  <= cfg_wdata;
                    2'd2:    route_tab[cfg_idx] <= cfg_wdata[NUM_OUTS-1:0];
`ifdef ROUTER_DEFAULT_ROUTE_EN
                    default: default_route      <= cfg_wdata[NUM_OUTS-1:0];
`else
                    default: ;
`endif
                endcase
            end

            if (drop_clr)
                drop_cnt <= '0;
            else if (drop_evt && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;

            if (accept && (lookup_route != '0)) begin
                state     <= HOLD;
                pending   <= lookup_route;
                opkt_data <= spkt_data;
                wait_cnt  <= '0;
            end else if (state == HOLD) begin
                if (remaining == '0 || timeout) begin
                    state    <= EMPTY;
                    pending  <= '0;
                    wait_cnt <= '0;
                end else if (any_acc) begin
                    pending  <= remaining;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_raggedstone_spinn_aer_if_key_router.sv
// Directed bench for the key router: lookup, replication, stall timeout, drops, back-to-back, reset.
module tb_raggedstone_spinn_aer_if_key_router;
    logic        clk;
    logic        rst;
    logic [71:0] spkt_data;
    logic        spkt_vld;
    logic        spkt_rdy;
    logic [71:0] opkt_data;
    logic [3:0]  opkt_vld;
    logic [3:0]  opkt_rdy;
    logic        cfg_wr;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [15:0] drop_cnt;
    logic        drop_clr;

    int n_checks = 0;
    int n_fail   = 0;

    raggedstone_spinn_aer_if_key_router dut (
        .clk       (clk),
        .rst       (rst),
        .spkt_data (spkt_data),
        .spkt_vld  (spkt_vld),
        .spkt_rdy  (spkt_rdy),
        .opkt_data (opkt_data),
        .opkt_vld  (opkt_vld),
        .opkt_rdy  (opkt_rdy),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .drop_cnt  (drop_cnt),
        .drop_clr  (drop_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] hdr, input logic [31:0] key);
        return {32'hC0DE_0000, key, hdr};
    endfunction

    task automatic cfg_write(input logic [1:0] entry, input logic [1:0] field, input logic [31:0] d);
        @(negedge clk);
        cfg_wr    = 1'b1;
        cfg_addr  = {entry, field};
        cfg_wdata = d;
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    initial begin
        int vld_cycles;
        int rdy_high;

        rst       = 1'b1;
        spkt_data = '0;
        spkt_vld  = 1'b0;
        opkt_rdy  = 4'b1111;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        drop_clr  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", opkt_vld, 4'b0000);
        chk("rst_data", opkt_data, 72'h0);
        chk("rst_rdy", spkt_rdy, 1'b1);
        chk("rst_drop", drop_cnt, 16'h0);
        rst = 1'b0;

        // default table sends every mc packet to output 0
        @(negedge clk);
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h00, 32'h1234_5678);
        @(negedge clk);
        spkt_vld = 1'b0;
        #1;
        chk("t1_vld", opkt_vld, 4'b0001);
        chk("t1_data", opkt_data, mk(8'h00, 32'h1234_5678));
        chk("t1_drop", drop_cnt, 16'h0);
        @(negedge clk);
        #1;
        chk("t1_vld_off", opkt_vld, 4'b0000);

        // replication with output 2 stalled for 3 cycles
        cfg_write(2'd1, 2'd0, 32'hFF00_0000);
        cfg_write(2'd1, 2'd1, 32'hFF00_0000);
        cfg_write(2'd1, 2'd2, 32'h0000_0006);
        cfg_write(2'd0, 2'd1, 32'hFFFF_FFFF);
        cfg_write(2'd0, 2'd0, 32'h0000_0000);
        @(negedge clk);
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h00, 32'hFF12_3456);
        opkt_rdy  = 4'b1011;
        #1;
        chk("t2_accept_rdy", spkt_rdy, 1'b1);
        @(negedge clk);
        spkt_vld = 1'b0;
        #1;
        chk("t2_vld_c1", opkt_vld, 4'b0110);
        chk("t2_data", opkt_data, mk(8'h00, 32'hFF12_3456));
        chk("t2_rdy_c1", spkt_rdy, 1'b0);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            #1;
            chk("t2_vld_stall", opkt_vld, 4'b0100);
            chk("t2_rdy_stall", spkt_rdy, 1'b0);
        end
        @(negedge clk);
        opkt_rdy = 4'b1111;
        #1;
        chk("t2_vld_c4", opkt_vld, 4'b0100);
        chk("t2_rdy_c4", spkt_rdy, 1'b1);
        @(negedge clk);
        #1;
        chk("t2_vld_done", opkt_vld, 4'b0000);
        chk("t2_drop", drop_cnt, 16'h0);

        // stall timeout
        @(negedge clk);
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h00, 32'hFF00_0001);
        opkt_rdy  = 4'b0000;
        vld_cycles = 0;
        rdy_high   = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            spkt_vld = 1'b0;
            #1;
            if (opkt_vld == 4'b0000)
                break;
            vld_cycles++;
            if (spkt_rdy)
                rdy_high++;
        end
        chk("t3_hold_cycles", vld_cycles, 255);
        chk("t3_rdy_in_hold", rdy_high, 0);
        chk("t3_drop", drop_cnt, 16'h1);
        chk("t3_rdy_after", spkt_rdy, 1'b1);
        opkt_rdy = 4'b1111;

        // non-multicast packet dropped at accept, then drop_clr wins over the increment
        @(negedge clk);
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h80, 32'h0000_0001);
        #1;
        chk("t4_rdy", spkt_rdy, 1'b1);
        @(negedge clk);
        spkt_vld = 1'b0;
        #1;
        chk("t4_vld", opkt_vld, 4'b0000);
        chk("t4_drop", drop_cnt, 16'h2);
        chk("t4_rdy_after", spkt_rdy, 1'b1);
        @(negedge clk);
        spkt_vld = 1'b1;
        drop_clr = 1'b1;
        @(negedge clk);
        spkt_vld = 1'b0;
        drop_clr = 1'b0;
        #1;
        chk("t4_clr_drop", drop_cnt, 16'h0);
        chk("t4_clr_vld", opkt_vld, 4'b0000);

        // 8 back-to-back packets, no bubble
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 8) begin
                spkt_vld  = 1'b1;
                spkt_data = mk(8'h00, 32'hFF00_0000 + 32'(i));
            end else begin
                spkt_vld = 1'b0;
            end
            #1;
            if (i < 8)
                chk("t5_rdy", spkt_rdy, 1'b1);
            if (i > 0) begin
                chk("t5_vld", opkt_vld, 4'b0110);
                chk("t5_data", opkt_data, mk(8'h00, 32'hFF00_0000 + 32'(i - 1)));
            end
        end
        @(negedge clk);
        #1;
        chk("t5_vld_end", opkt_vld, 4'b0000);

        // reset in the middle of a stream
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            spkt_vld  = 1'b1;
            spkt_data = mk(8'h00, 32'hFF00_0010 + 32'(i));
            if (i == 4)
                rst = 1'b1;
        end
        @(negedge clk);
        rst      = 1'b0;
        spkt_vld = 1'b0;
        #1;
        chk("t5_rst_vld", opkt_vld, 4'b0000);
        chk("t5_rst_drop", drop_cnt, 16'h0);
        chk("t5_rst_rdy", spkt_rdy, 1'b1);

        // cfg write lands the cycle after; same-cycle lookup sees the old route
        @(negedge clk);
        cfg_wr    = 1'b1;
        cfg_addr  = {2'd0, 2'd2};
        cfg_wdata = 32'h0000_0004;
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h00, 32'h0000_0042);
        @(negedge clk);
        cfg_wr    = 1'b0;
        spkt_data = mk(8'h00, 32'h0000_0043);
        #1;
        chk("t6_old_route", opkt_vld, 4'b0001);
        @(negedge clk);
        spkt_vld = 1'b0;
        #1;
        chk("t6_new_route", opkt_vld, 4'b0100);

        // multicast miss: default route when enabled, otherwise dropped
        for (int e = 0; e < 4; e++)
            cfg_write(2'(e), 2'd1, 32'hFFFF_FFFF);
        cfg_write(2'd0, 2'd3, 32'h0000_0008);
        @(negedge clk);
        spkt_vld  = 1'b1;
        spkt_data = mk(8'h00, 32'h0000_1234);
        @(negedge clk);
        spkt_vld = 1'b0;
        #1;
`ifdef ROUTER_DEFAULT_ROUTE_EN
        chk("t6_miss_vld", opkt_vld, 4'b1000);
        chk("t6_miss_drop", drop_cnt, 16'h0);
`else
        chk("t6_miss_vld", opkt_vld, 4'b0000);
        chk("t6_miss_drop", drop_cnt, 16'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
